dmem_ctrl: RTL and testbench

Parametrised data-memory controller that replaces the single-cycle combinational data memory on the core's load/store path. It accepts one RV32I load/store at a time over a valid/ready request channel and performs byte/halfword/word access with sign/zero extension. It flags misaligned, out-of-range and illegal accesses, and inserts a configurable number of wait states. After reset it clears its array word by word, so no multi-word reset loop exists in RTL.

---
 rtl/dmem_ctrl_pkg.sv | 31 +++
 rtl/dmem_lane_align.sv | 54 +++++
 rtl/dmem_ctrl.sv | 158 +++++++++++++++
 tb/tb_dmem_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared funct3 codes, FSM encoding and access-legality helper
// for the data-memory controller and its lane aligner.
package dmem_ctrl_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    DM_CLEAR,
    DM_IDLE,
    DM_WAIT,
    DM_ACCESS,
    DM_RESP
  } dm_state_e;

  // Unsigned widths only make sense for loads.
  function automatic logic f3_illegal(
    input logic       we,
    input logic [2:0] f3
  );
    logic bad;
    bad = (f3 == 3'b011) || (f3[2:1] == 2'b11);
    if (we && (f3 == F3_BU || f3 == F3_HU))
      bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Store byte-enable/replication and load lane extraction with
// sign or zero extension; purely combinational.
module dmem_lane_align
  import dmem_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wlane,
  output logic [31:0] rdata
);

  logic [31:0] bsh;
  logic [31:0] hsh;

  assign bsh = rword >> {off, 3'b000};
  assign hsh = rword >> {off[1], 4'b0000};

  always_comb begin
    be    = 4'b0000;
    wlane = wdata;
    rdata = '0;
    case (funct3)
      F3_B: begin
        be    = 4'b0001 << off;
        wlane = {4{wdata[7:0]}};
        rdata = {{24{bsh[7]}}, bsh[7:0]};
      end
      F3_BU: begin
        be    = 4'b0001 << off;
        wlane = {4{wdata[7:0]}};
        rdata = {24'h0, bsh[7:0]};
      end
      F3_H: begin
        be    = 4'b0011 << {off[1], 1'b0};
        wlane = {2{wdata[15:0]}};
        rdata = {{16{hsh[15]}}, hsh[15:0]};
      end
      F3_HU: begin
        be    = 4'b0011 << {off[1], 1'b0};
        wlane = {2{wdata[15:0]}};
        rdata = {16'h0, hsh[15:0]};
      end
      F3_W: begin
        be    = 4'b1111;
        rdata = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Multi-cycle RV32I data-memory controller: valid/ready request,
// optional wait states, fault detection and post-reset array clear.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DEPTH        = 1024,
  parameter int WAIT_STATES  = 0,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              busy_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] WS_INIT =
    4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  dm_state_e         state;
  logic [IDX_W-1:0]  clr_idx;
  logic [3:0]        wcnt;
  logic              q_we;
  logic [2:0]        q_f3;
  logic [ADDR_W-1:0] q_addr;
  logic [31:0]       q_wdata;

  logic [31:0]       mem [DEPTH];

  logic [IDX_W-1:0]  idx;
  logic              misal;
  logic              oor;
  logic              err;
  logic [31:0]       rword;
  logic [3:0]        st_be;
  logic [31:0]       st_data;
  logic [31:0]       ld_data;

  logic              mem_we;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wd;
  logic [IDX_W-1:0]  mem_idx;

  assign idx   = q_addr[IDX_W+1:2];
  assign oor   = (q_addr >> 2) >= ADDR_W'(DEPTH);
  assign err   = misal | oor | f3_illegal(q_we, q_f3);
  assign rword = mem[idx];

  assign req_ready_o = (state == DM_IDLE) && !rst;
  assign busy_o      = (state == DM_CLEAR);

  always_comb begin
    misal = 1'b0;
    case (q_f3)
      F3_H, F3_HU: misal = q_addr[0];
      F3_W:        misal = |q_addr[1:0];
      default:     misal = 1'b0;
    endcase
  end

  dmem_lane_align u_align (
    .funct3 (q_f3),
    .off    (q_addr[1:0]),
    .wdata  (q_wdata),
    .rword  (rword),
    .be     (st_be),
    .wlane  (st_data),
    .rdata  (ld_data)
  );

  always_comb begin
    mem_we  = 1'b0;
    mem_be  = 4'b0000;
    mem_wd  = '0;
    mem_idx = idx;
    if (state == DM_CLEAR) begin
      mem_we  = 1'b1;
      mem_be  = 4'b1111;
      mem_idx = clr_idx;
    end else if (state == DM_ACCESS && q_we && !err) begin
      mem_we = 1'b1;
      mem_be = st_be;
      mem_wd = st_data;
    end
    if (rst)
      mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b])
          mem[mem_idx][8*b +: 8] <= mem_wd[8*b +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= (CLEAR_ON_RST != 0) ? DM_CLEAR : DM_IDLE;
      clr_idx     <= '0;
      wcnt        <= '0;
      q_we        <= 1'b0;
      q_f3        <= '0;
      q_addr      <= '0;
      q_wdata     <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      unique case (state)
        DM_CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == IDX_W'(DEPTH - 1))
            state <= DM_IDLE;
        end
        DM_IDLE: begin
          if (req_valid_i) begin
            q_we    <= req_we_i;
            q_f3    <= req_funct3_i;
            q_addr  <= req_addr_i;
            q_wdata <= req_wdata_i;
            wcnt    <= WS_INIT;
            state   <= (WAIT_STATES > 0) ? DM_WAIT : DM_ACCESS;
          end
        end
        DM_WAIT: begin
          if (wcnt == 4'd0)
            state <= DM_ACCESS;
          else
            wcnt <= wcnt - 4'd1;
        end
        DM_ACCESS: begin
          rsp_valid_o <= 1'b1;
          rsp_err_o   <= err;
          rsp_rdata_o <= (err || q_we) ? 32'h0 : ld_data;
          state       <= DM_RESP;
        end
        DM_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= DM_IDLE;
          end
        end
        default: state <= DM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: DEPTH=16, three wait states,
// clear-on-reset enabled.
module tb_dmem_ctrl;
  import dmem_ctrl_pkg::*;

  localparam int DEPTH = 16;
  localparam int WS    = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(
    .ADDR_W       (32),
    .DEPTH        (DEPTH),
    .WAIT_STATES  (WS),
    .CLEAR_ON_RST (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_funct3_i (req_funct3_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o),
    .busy_o       (busy_o)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!req_ready_o && n < 200) begin
      tick();
      n++;
    end
  endtask

  // lat = edges from the accept edge to the edge that sees rsp_valid_o
  task automatic xfer(
    input  logic        we,
    input  logic [2:0]  f3,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        er,
    output int          lat
  );
    int n;
    wait_ready(n);
    req_valid_i  = 1'b1;
    req_we_i     = we;
    req_funct3_i = f3;
    req_addr_i   = addr;
    req_wdata_i  = wd;
    tick();
    req_valid_i  = 1'b0;
    req_wdata_i  = 32'h5A5A5A5A;
    lat = 1;
    while (!rsp_valid_o && lat < 100) begin
      tick();
      lat++;
    end
    rd = rsp_rdata_o;
    er = rsp_err_o;
    if (rsp_ready_i)
      tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] held;
    logic        er;
    int          lat;
    int          n;

    rst          = 1'b1;
    req_valid_i  = 1'b0;
    req_we_i     = 1'b0;
    req_funct3_i = 3'b000;
    req_addr_i   = '0;
    req_wdata_i  = '0;
    rsp_ready_i  = 1'b1;
    tick();
    tick();
    check("rst_ready", req_ready_o, 0);
    check("rst_valid", rsp_valid_o, 0);
    check("rst_busy",  busy_o, 1);
    check("rst_rdata", rsp_rdata_o, 0);
    check("rst_err",   rsp_err_o, 0);

    rst = 1'b0;
    wait_ready(n);
    check("clr_cycles", n, DEPTH);
    check("clr_busy", busy_o, 0);

    for (int i = 0; i < DEPTH; i++) begin
      xfer(1'b0, F3_W, 32'(i * 4), 0, rd, er, lat);
      check($sformatf("zero_w%0d", i), rd, 0);
    end

    xfer(1'b1, F3_W, 32'h4, 32'h8899AABB, rd, er, lat);
    check("sw_err", er, 0);
    check("sw_rdata", rd, 0);
    xfer(1'b1, F3_B, 32'h6, 32'h00000011, rd, er, lat);
    check("sb_err", er, 0);
    xfer(1'b0, F3_W, 32'h4, 0, rd, er, lat);
    check("lw4", rd, 32'h8811AABB);
    xfer(1'b0, F3_B, 32'h7, 0, rd, er, lat);
    check("lb7", rd, 32'hFFFFFF88);
    xfer(1'b0, F3_BU, 32'h7, 0, rd, er, lat);
    check("lbu7", rd, 32'h00000088);

    xfer(1'b1, F3_H, 32'h2, 32'h1234F00D, rd, er, lat);
    check("sh_err", er, 0);
    xfer(1'b0, F3_H, 32'h2, 0, rd, er, lat);
    check("lh2", rd, 32'hFFFFF00D);
    xfer(1'b0, F3_HU, 32'h2, 0, rd, er, lat);
    check("lhu2", rd, 32'h0000F00D);
    xfer(1'b0, F3_W, 32'h0, 0, rd, er, lat);
    check("lw0", rd, 32'hF00D0000);
    xfer(1'b0, F3_H, 32'h1, 0, rd, er, lat);
    check("lh1_err", er, 1);
    check("lh1_rdata", rd, 0);

    xfer(1'b1, F3_W, 32'h40, 32'hCAFEBABE, rd, er, lat);
    check("oor_err", er, 1);
    xfer(1'b0, F3_W, 32'h0, 0, rd, er, lat);
    check("oor_w0", rd, 32'hF00D0000);
    xfer(1'b1, F3_BU, 32'h8, 32'h000000EE, rd, er, lat);
    check("sbu_err", er, 1);
    xfer(1'b0, F3_W, 32'h8, 0, rd, er, lat);
    check("sbu_w2", rd, 0);
    check("lw8_err", er, 0);
    xfer(1'b0, 3'b111, 32'h4, 0, rd, er, lat);
    check("ld111_err", er, 1);
    check("ld111_rdata", rd, 0);

    rsp_ready_i = 1'b0;
    xfer(1'b0, F3_W, 32'h4, 0, rd, er, lat);
    check("lat", lat, 2 + WS);
    check("stall_rd", rd, 32'h8811AABB);
    held = rsp_rdata_o;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_valid", rsp_valid_o, 1);
      check("stall_rdata", rsp_rdata_o, held);
      check("stall_ready", req_ready_o, 0);
    end
    rsp_ready_i = 1'b1;
    tick();
    check("hs_valid", rsp_valid_o, 0);
    check("hs_ready", req_ready_o, 1);

    rsp_ready_i = 1'b0;
    xfer(1'b0, F3_W, 32'h4, 0, rd, er, lat);
    check("rsp_pend", rsp_valid_o, 1);
    rst = 1'b1;
    tick();
    check("rst_resp_valid", rsp_valid_o, 0);
    rst = 1'b0;
    rsp_ready_i = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check("rst_clr_busy", busy_o, 1);
    rst = 1'b0;
    wait_ready(n);
    check("clr_restart", n, DEPTH);

    wait_ready(n);
    req_valid_i  = 1'b1;
    req_we_i     = 1'b1;
    req_funct3_i = F3_W;
    req_addr_i   = 32'h8;
    req_wdata_i  = 32'hDEADBEEF;
    tick();
    req_valid_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("wait_rst_valid", rsp_valid_o, 0);
    check("wait_rst_ready", req_ready_o, 0);
    rst = 1'b0;
    wait_ready(n);
    check("wait_rst_clr", n, DEPTH);
    xfer(1'b0, F3_W, 32'h8, 0, rd, er, lat);
    check("wait_rst_w2", rd, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
